// File: rtl/count_snapshot_fifo.sv
// Watches an upstream free-running 8-bit counter for step errors and wraps, and
// captures {epoch, count} snapshots on a match into a small first-word-fall-through FIFO.
module count_snapshot_fifo #(
    parameter int DEPTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   count,
    input  logic [7:0]                   match_val,
    input  logic                         match_en,
    output logic [WRAP_W+7:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [WRAP_W-1:0]            wrap_cnt,
    output logic                         seq_err,
    output logic                         overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int DW = WRAP_W + 8;
    localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
    localparam logic [LW-1:0]     LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);
    localparam logic [WRAP_W-1:0] EPOCH_ONE = WRAP_W'(1);

    logic [DW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [7:0]        prev_count;
    logic              primed;

    logic              wrap_now;
    logic              step_err;
    logic              push;
    logic              pop;
    logic              full;
    logic              do_push;
    logic [WRAP_W-1:0] epoch_next;

    always_comb begin
        wrap_now   = primed && (prev_count == 8'hFF) && (count == 8'h00);
        step_err   = primed && (count != prev_count + 8'd1);
        epoch_next = wrap_now ? wrap_cnt + EPOCH_ONE : wrap_cnt;
        push       = match_en && (count == match_val);
        full       = (level == LVL_FULL);
        pop        = out_valid && out_ready;
        // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
        do_push    = push && (!full || pop);
    end

    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            prev_count <= '0;
            primed     <= 1'b0;
            wrap_cnt   <= '0;
            seq_err    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            prev_count <= count;
            primed     <= 1'b1;
            wrap_cnt   <= epoch_next;
            if (step_err) begin
                seq_err <= 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (do_push) begin
                mem[wr_ptr] <= {epoch_next, count};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Bench for count_snapshot_fifo: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the snapshot FIFO.
module tb_count_snapshot_fifo;
    localparam int DEPTH  = 4;
    localparam int WRAP_W = 8;
    localparam int DW     = WRAP_W + 8;
    localparam int LW     = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    count = '0;
    logic [7:0]    match_val = '0;
    logic          match_en = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] level;
    logic [WRAP_W-1:0] wrap_cnt;
    logic          seq_err;
    logic          overflow;

    count_snapshot_fifo #(.DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
        .clk(clk), .reset(reset), .count(count), .match_val(match_val),
        .match_en(match_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .wrap_cnt(wrap_cnt),
        .seq_err(seq_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit m_primed;
    int m_prev;
    int m_epoch;
    bit m_seq;
    bit m_ovf;
    int m_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_primed = 0; m_prev = 0; m_epoch = 0; m_seq = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_edge();
        bit push, pop;
        int c;
        c = int'(count);
        if (m_primed) begin
            if (m_prev == 255 && c == 0) m_epoch = (m_epoch + 1) % (1 << WRAP_W);
            if (c != (m_prev + 1) % 256) m_seq = 1;
        end
        push = match_en && (count == match_val);
        pop  = (m_q.size() > 0) && out_ready;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_epoch * 256 + c);
            else m_ovf = 1;
        end
        m_prev = c;
        m_primed = 1;
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("level", 32'(level), 32'(m_q.size()));
        check("wrap_cnt", 32'(wrap_cnt), 32'(m_epoch));
        check("seq_err", 32'(seq_err), 32'(m_seq));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() > 0) check("out_data", 32'(out_data), 32'(m_q[0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            count = count + 8'd1;
        end
    endtask

    // Asserts reset between clock edges, checks the asynchronous clear, then releases it.
    task automatic do_reset(input logic [7:0] start);
        #1 reset = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_wrap", 32'(wrap_cnt), 0);
        check("rst_seq", 32'(seq_err), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_data", 32'(out_data), 0);
        model_clear();
        match_en = 1'b0;
        out_ready = 1'b0;
        count = start;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int got[$];
        int max_lvl;
        bit found;
        logic [7:0] new_cnt;

        // free-run, wrap counting
        do_reset(8'h00);
        run(256);
        check("wrap0", 32'(wrap_cnt), 0);
        run(1);
        check("wrap1", 32'(wrap_cnt), 1);
        run(255);
        check("wrap1_hold", 32'(wrap_cnt), 1);
        run(1);
        check("wrap2", 32'(wrap_cnt), 2);
        run(87);
        check("freerun_seq", 32'(seq_err), 0);

        // capture with continuous drain
        do_reset(8'h00);
        match_val = 8'h10; match_en = 1'b1; out_ready = 1'b1;
        max_lvl = 0;
        for (int i = 0; i < 520; i++) begin
            cycle();
            count = count + 8'd1;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (out_valid) got.push_back(int'(out_data));
        end
        check("drain_n", 32'(got.size()), 2);
        if (got.size() >= 2) begin
            check("drain_w0", 32'(got[0]), 32'h0010);
            check("drain_w1", 32'(got[1]), 32'h0110);
        end
        check("drain_maxlvl", 32'(max_lvl <= 1), 1);

        // overflow with no drain
        do_reset(8'h00);
        match_val = 8'h05; match_en = 1'b1; out_ready = 1'b0;
        run(5 * 256);
        check("ovf_level", 32'(level), 4);
        check("ovf_flag", 32'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_pop", 32'(out_data), 32'(i * 256 + 5));
            cycle();
            count = count + 8'd1;
        end
        check("ovf_empty_lvl", 32'(level), 0);
        check("ovf_empty_vld", 32'(out_valid), 0);

        // epoch boundary capture
        do_reset(8'hF0);
        match_val = 8'h00; match_en = 1'b1; out_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            count = count + 8'd1;
            if (out_valid) begin
                found = 1;
                check("epoch_word", 32'(out_data), 32'h0100);
            end
        end
        check("epoch_found", 32'(found), 1);

        // discontinuity
        do_reset(8'h1C);
        run(4);
        cycle();
        count = 8'h22;
        cycle();
        check("disc_seq", 32'(seq_err), 1);
        count = 8'h23;
        run(300);
        check("disc_sticky", 32'(seq_err), 1);

        // reset mid-stream, then a clean restart at 0x7A
        do_reset(8'h40);
        match_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            match_val = count;
            cycle();
            count = count + 8'd1;
        end
        match_en = 1'b0;
        check("mid_level", 32'(level), 3);
        count = count + 8'd5;
        cycle();
        check("mid_seq", 32'(seq_err), 1);
        do_reset(8'h7A);
        cycle();
        count = 8'h7B;
        cycle();
        check("restart_seq", 32'(seq_err), 0);

        // simultaneous push and pop while full
        do_reset(8'h30);
        match_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            match_val = count;
            cycle();
            count = count + 8'd1;
        end
        check("full_level", 32'(level), 4);
        out_ready = 1'b1;
        match_val = count;
        new_cnt = count;
        cycle();
        count = count + 8'd1;
        match_en = 1'b0;
        check("pp_level", 32'(level), 4);
        check("pp_ovf", 32'(overflow), 0);
        run(3);
        check("pp_last", 32'(out_data), 32'({8'h00, new_cnt}));
        run(1);

        // randomized traffic
        do_reset(8'($urandom_range(0, 255)));
        for (int blk = 0; blk < 6; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 2 == 0) ? 80 : 15;
            for (int i = 0; i < 500; i++) begin
                match_en  = ($urandom_range(0, 3) != 0);
                match_val = ($urandom_range(0, 2) == 0) ? count : 8'($urandom_range(0, 255));
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                cycle();
                if ($urandom_range(0, 199) == 0) count = 8'($urandom_range(0, 255));
                else count = count + 8'd1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
- Downstream consumer of the 8-bit free-running counter output, `count`, on the same clock.
- Checks that `count` advances by exactly +1 each cycle, modulo 256.
- Tracks wrap-arounds in an epoch counter.
- On a programmable match value, captures an {epoch, count} snapshot into a small first-word-fall-through FIFO, drained by a valid/ready handshake.

Parameters:
- DEPTH, 4: FIFO entries. Power of 2, minimum 2.
- WRAP_W, 8: width of the wrap/epoch counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- count  input  8  upstream counter value, sampled every cycle.
- match_val  input  8  capture compare value.
- match_en  input  1  enables capture on match.
- out_data  output  WRAP_W+8  FIFO head: {epoch, count}.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head this cycle.
- level  output  clog2(DEPTH+1)  FIFO occupancy.
- wrap_cnt  output  WRAP_W  number of 0xFF to 0x00 transitions since reset.
- seq_err  output  1  sticky: discontinuity detected.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, immediate, independent of clk):
  - out_valid, level, wrap_cnt, seq_err and overflow are 0.
  - out_data is 0; FIFO pointers cleared; prev_count is 0; primed is 0.
- Priming: the first rising edge after reset deassertion loads prev_count and sets primed=1. No checks run while primed=0.
- Per cycle, once primed=1 (combinational on inputs and registers, committed at the edge):
  - wrap_now = (prev_count==8'hFF) && (count==8'h00).
  - step_err = (count != prev_count+1 mod 256).
  - prev_count <= count every cycle.
- wrap_cnt:
  - Increments on wrap_now.
  - Wraps modulo 2^WRAP_W and never saturates.
  - Visible the cycle after the 0x00 sample.
- seq_err: set on step_err; sticky until reset.
- Capture:
  - push = match_en && (count==match_val). Match is evaluated even when primed=0.
  - Pushed word is {wrap_cnt + wrap_now, count}, i.e. the post-increment epoch. A count of 0x00 belongs to the new epoch.
- FIFO:
  - First-word-fall-through: out_valid = (level != 0); out_data = head entry.
  - out_data holds its last value when empty; it is not required to be 0 after the first pop.
  - pop = out_valid && out_ready.
  - Push latency is 1 cycle: the entry is visible on out_data at the next cycle. There is no combinational bypass when empty.
  - Push and pop in the same cycle: both take effect and level is unchanged. This includes the full case; the push is not dropped.
  - Push when full without a pop: the entry is dropped, overflow <= 1 (sticky), and FIFO contents and level are unchanged.
  - Pop when empty: impossible by definition of pop; no state change.
  - Pointers are log2(DEPTH) bits and wrap naturally; level is DEPTH when full.
- out_data, out_valid and level are stable while out_ready=0. Head data never changes until popped.

Test Plan:
- Free-run, match_en=0 → seq_err=0 throughout.
  - Stimulus: release reset with the upstream counter free-running from 0; run 600 cycles.
  - Response: wrap_cnt=1 one cycle after the first 0xFF to 0x00 step, and 2 after the second.
- Capture with continuous drain → one pushed word per pass, in epoch order.
  - Stimulus: match_val=0x10, match_en=1, out_ready=1.
  - Response: out_valid pulses 1 cycle after count==0x10; out_data=0x0010 in the first pass and 0x0110 in the second; level never exceeds 1.
- Overflow with DEPTH=4 and no drain → level stops at 4 and overflow sets.
  - Stimulus: match_val=0x05, out_ready=0, run 5 passes.
  - Response: level=4; overflow=1 after the 5th match; then out_ready=1 pops 0x0005, 0x0105, 0x0205, 0x0305 in order; level=0, out_valid=0.
- Epoch boundary → post-increment epoch is captured.
  - Stimulus: match_val=0x00.
  - Response: word pushed at the first wrap is 0x0100, not 0x0000.
- Discontinuity → seq_err=1 on the following cycle.
  - Stimulus: force count 0x20 then 0x22.
  - Response: seq_err=1 the following cycle; still 1 after 300 further clean cycles; cleared only by reset.
- Reset mid-stream → all outputs clear immediately, no priming error.
  - Stimulus: with level=3 and seq_err=1, assert reset between clock edges.
  - Response: out_valid, level, wrap_cnt, seq_err and overflow go 0 without a clock edge.
  - After release with count=0x7A, the next cycle's count=0x7B raises no seq_err.
- Simultaneous push/pop at full.
  - Stimulus: level=4, out_ready=1, match in the same cycle.
  - Response: level stays 4; overflow stays 0; the new word appears last in pop order.
